inst_fetch_unit: RTL
====================

# inst_fetch_unit

Instruction fetch front end of the 3-stage RISC-V pipeline. Owns the PC, issues word requests to instruction memory through a valid/ready handshake, and collects in-order responses into a small queue. Presents {pc, inst, valid} to the IF/ID pipeline register. Handles downstream stall and branch/jump redirect, including discard of in-flight responses.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- FIFO_DEPTH, 2: response queue entries; power of two, ≥2; also bounds requests in flight.

- clk  in  1  clock.
- rst  in  1  reset rst, synchronous, active-high.
- imem_req_valid  out  1  request valid.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_rsp_valid  in  1  response valid; in order, latency ≥1 cycle.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  branch/jump taken, single-cycle pulse or level.
- redirect_pc  in  32  new fetch target.
- stall  in  1  downstream not accepting this cycle.
- fetch_valid  out  1  queue head valid.
- fetch_pc  out  32  PC of head instruction.
- fetch_inst  out  32  head instruction.
- fetch_misalign  out  1  misaligned redirect detected (see Configuration).

## Operation
- State: pc_q (next request address), queue of {pc, inst} (FIFO_DEPTH), addr-tag queue for in-flight PCs, outstanding counter, drop counter.
- Issue: imem_req_valid = !rst && !redirect_valid && !halted && (outstanding + count − deq) < FIFO_DEPTH, where deq = fetch_valid && !stall. imem_req_addr = pc_q. On valid&&ready: pc_q += 4 (wraps modulo 2^32), push pc_q to tag queue, outstanding++.
- Response: on imem_rsp_valid, outstanding--, pop tag. If drop_cnt > 0: discard, drop_cnt--. Else enqueue {tag, data}.
- Output: fetch_valid = count != 0. Valid: head fields. Invalid: fetch_pc = 0, fetch_inst = NOP (32'h0000_0013).
- Dequeue when fetch_valid && !stall; stall holds head stable.
- Redirect (highest priority): queue cleared; pc_q <= redirect_pc; drop_cnt <= outstanding + (request accepted this cycle ? 1 : 0) − (rsp_valid and not already dropping ? 1 : 0) + existing drop_cnt adjusted; i.e. every response for a pre-redirect request is discarded. No request issued in redirect cycle.
- Simultaneous enqueue and dequeue: count unchanged. Response never arrives into a full queue (credit rule); arrival with outstanding==0 is a protocol error (assertion).
- Reset: pc_q = RESET_PC, queue empty, outstanding = 0, drop_cnt = 0, halted = 0.

## Timing
- Reset values: imem_req_valid 0, imem_req_addr RESET_PC, fetch_valid 0, fetch_pc 0, fetch_inst NOP, fetch_misalign 0.
- Cycle 0 = first cycle rst low: request RESET_PC. 1-cycle memory: response cycle 1, fetch_valid cycle 2.
- Sustained throughput 1 instr/cycle with 1-cycle memory, FIFO_DEPTH ≥2, no stall.
- Redirect in cycle N: fetch_valid 0 in N+1; request to redirect_pc in N+1; first valid instr N+3 with 1-cycle memory.
- All outputs registered or decoded from registered state only; no combinational path from imem_rsp_* or stall to imem_req_valid other than the deq credit term.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined: redirect with redirect_pc[1:0] != 0 sets halted and fetch_misalign (from next cycle); no further requests; queue empty; cleared only by next aligned redirect or reset.
- Undefined: redirect_pc[1:0] forced to 00; fetch_misalign tied 0; no halted state.

## Structure
- Package fetch_pkg: NOP_INST constant, fetch_entry_t struct {pc, inst}, counter width localparam derived from FIFO_DEPTH.
- One sub-module: fetch_fifo (parameterized synchronous FIFO, flush input), instantiated twice (tag queue, response queue).

## Test plan
- Reset then 1-cycle memory, no stall → requests 0x0,0x4,0x8…; fetch_valid from cycle 2, one instr/cycle, pc matches data.
- stall held 5 cycles with queue full → imem_req_valid 0, fetch_pc/inst unchanged; release → resumes without loss or duplicate.
- Memory latency 3, ready toggling → in-order delivery, outstanding never exceeds FIFO_DEPTH.
- redirect_pc=0x100 with 2 responses in flight → both discarded, next fetch_pc 0x100 then 0x104.
- Redirect coincident with response and dequeue → no stale instruction reaches output.
- Macro on, redirect_pc=0x102 → fetch_misalign 1, no requests; redirect 0x200 clears it. Macro off → fetches 0x100.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam int          FETCH_FIFO_DEPTH = 2;
  localparam int          FETCH_CNT_W      = $clog2(FETCH_FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Counter width able to hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; flush and reset take priority over push/pop.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  // A full queue can still accept when the head leaves in the same cycle.
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: PC, imem request/response handshake, response queue.
// Optional FETCH_MISALIGN_CHECK_EN halts fetch on a misaligned redirect target.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = FETCH_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_inst,
  output logic        fetch_misalign
);

  localparam int CW = cnt_width(FIFO_DEPTH);

  logic [31:0]   pc_q;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] count;
  logic [CW-1:0] drop_cnt;
  logic [CW:0]   credit;
  logic [31:0]   tag_head;
  logic [31:0]   redirect_tgt;
  fetch_entry_t  rsp_head;
  fetch_entry_t  rsp_entry;
  logic          halted;
  logic          deq;
  logic          accept;
  logic          enq;
  logic          dropping;

  assign fetch_valid = count != '0;
  assign deq         = fetch_valid && !stall;

  // Every in-flight request owns a queue slot; a departing head frees one now.
  assign credit = {1'b0, outstanding} + {1'b0, count} - (CW+1)'(deq);

  assign imem_req_valid = !rst && !redirect_valid && !halted &&
                          (credit < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  assign dropping  = drop_cnt != '0;
  assign enq       = imem_rsp_valid && !dropping && !redirect_valid;
  assign rsp_entry = '{pc: tag_head, inst: imem_rsp_data};

  assign fetch_pc   = fetch_valid ? rsp_head.pc   : 32'h0;
  assign fetch_inst = fetch_valid ? rsp_head.inst : NOP_INST;

  // Tag queue is never flushed: responses to squashed requests still pop it.
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_tag_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .push      (accept),
    .push_data (pc_q),
    .pop       (imem_rsp_valid),
    .head      (tag_head),
    .count     (outstanding)
  );

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(fetch_entry_t))) u_rsp_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (enq),
    .push_data (rsp_entry),
    .pop       (deq),
    .head      (rsp_head),
    .count     (count)
  );

`ifdef FETCH_MISALIGN_CHECK_EN
  assign redirect_tgt   = redirect_pc;
  assign fetch_misalign = halted;

  always_ff @(posedge clk) begin
    if (rst)                 halted <= 1'b0;
    else if (redirect_valid) halted <= redirect_pc[1:0] != 2'b00;
  end
`else
  assign redirect_tgt   = redirect_pc & ~32'h3;
  assign halted         = 1'b0;
  assign fetch_misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      // No request issues this cycle, so whatever stays outstanding is stale.
      pc_q     <= redirect_tgt;
      drop_cnt <= outstanding - CW'(imem_rsp_valid);
    end else begin
      if (accept)                     pc_q     <= pc_q + 32'd4;
      if (imem_rsp_valid && dropping) drop_cnt <= drop_cnt - CW'(1);
    end
  end

  rsp_has_request: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> outstanding != '0);

endmodule
